// File: rtl/modulus_quint_accum_if.sv
// Operand/result handshake bundle for modulus_quint_accum.
// The master side issues operands and accepts results; the slave side is the accumulator.
interface modulus_quint_accum_if #(
    parameter int MODULUS_WIDTH = 1024,
    parameter int NUM_QUINTS    = 8
);
    localparam int ACC_WIDTH = MODULUS_WIDTH + $clog2(NUM_QUINTS + 1);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [MODULUS_WIDTH+5*NUM_QUINTS-1:0] in_data;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [ACC_WIDTH-1:0]                  out_data;
    logic                                  busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/modulus_quint_accum.sv
// Folds NUM_QUINTS 5-bit quints above bit W-1 into a running residue sum, one quint per cycle.
// Optional macro MODQ_FINAL_SUB_EN adds a REDUCE state that brings out_data below the modulus.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready high
// ACCUM  | adding the residue of quint cnt to acc
// REDUCE | subtracting the modulus while acc >= M (MODQ_FINAL_SUB_EN only)
// DONE   | result presented, held until out_ready
`ifndef MODULUS_DEF
`define MODULUS_DEF (~1024'd0 - 1024'd104)
`endif

module modulus_quint_accum #(
    parameter int MODULUS_WIDTH = 1024,
    parameter int NUM_QUINTS    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    modulus_quint_accum_if.slave bus
);
    localparam int W         = MODULUS_WIDTH;
    localparam int N         = NUM_QUINTS;
    localparam int ACC_WIDTH = W + $clog2(N + 1);
    localparam int CW        = (N > 1) ? $clog2(N) : 1;

    // The modulus must have bit W-1 set, so 2^W mod M is simply 2^W - M.
    localparam logic [W-1:0] MOD = W'(`MODULUS_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_REDUCE,
        S_DONE
    } state_t;

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MOD})
            s = s - {1'b0, MOD};
        return s[W-1:0];
    endfunction

    // Residue of q * 2^(W+5k) mod M, evaluated at elaboration time.
    function automatic logic [W-1:0] rom_entry(input int k, input int q);
        logic [W-1:0] base;
        logic [W-1:0] r;
        base = ~MOD + W'(1);
        for (int i = 0; i < 5 * k; i++)
            base = add_mod(base, base);
        r = '0;
        for (int j = 0; j < q; j++)
            r = add_mod(r, base);
        return r;
    endfunction

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [CW-1:0]          cnt_q;
    logic [5*N-1:0]         shadow_q;

    logic [W-1:0]           rom_out [N];
    logic [W-1:0]           rom_sel_d;
    logic [ACC_WIDTH-1:0]   acc_sum_d;

    for (genvar k = 0; k < N; k++) begin : g_quint
        logic [W-1:0] tbl [32];
        for (genvar q = 0; q < 32; q++) begin : g_ent
            localparam logic [W-1:0] ENT = rom_entry(k, q);
            assign tbl[q] = ENT;
        end
        assign rom_out[k] = tbl[shadow_q[5*k +: 5]];
    end

    assign rom_sel_d = rom_out[cnt_q];
    assign acc_sum_d = acc_q + {{(ACC_WIDTH-W){1'b0}}, rom_sel_d};

`ifdef MODQ_FINAL_SUB_EN
    localparam logic [ACC_WIDTH-1:0] MOD_ACC = {{(ACC_WIDTH-W){1'b0}}, MOD};
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        acc_q      <= {{(ACC_WIDTH-W){1'b0}}, bus.in_data[W-1:0]};
                        shadow_q   <= bus.in_data[W+5*N-1:W];
                        cnt_q      <= '0;
                        state_q    <= S_ACCUM;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_sum_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
`ifdef MODQ_FINAL_SUB_EN
                        state_q     <= S_REDUCE;
`else
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef MODQ_FINAL_SUB_EN
                S_REDUCE: begin
                    if (acc_q >= MOD_ACC) begin
                        acc_q <= acc_q - MOD_ACC;
                    end else begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_modulus_quint_accum.sv
// Scoreboard bench for modulus_quint_accum: expected sums come from a wide-arithmetic model of
// the operand's quint residues (or the plain operand mod M when MODQ_FINAL_SUB_EN is defined).
`ifndef MODULUS_DEF
`define MODULUS_DEF (~1024'd0 - 1024'd104)
`endif

module tb_modulus_quint_accum;
    localparam int W   = 1024;
    localparam int N   = 8;
    localparam int AW  = W + $clog2(N + 1);
    localparam int TOT = W + 5 * N;
    localparam int BW  = TOT + 8;
    localparam logic [W-1:0] MOD = W'(`MODULUS_DEF);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    modulus_quint_accum_if #(.MODULUS_WIDTH(W), .NUM_QUINTS(N)) bus ();

    modulus_quint_accum #(.MODULUS_WIDTH(W), .NUM_QUINTS(N)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [AW-1:0] exp_q [$];
    bit rdy_rand = 1'b0;

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got low64=%h want low64=%h (t=%0t)", name, got[63:0], want[63:0], $time);
        end
    endtask

    function automatic logic [AW-1:0] model(input logic [TOT-1:0] d);
        logic [BW-1:0] m;
        logic [BW-1:0] sum;
        m = BW'(MOD);
`ifdef MODQ_FINAL_SUB_EN
        sum = BW'(d) % m;
`else
        sum = BW'(d[W-1:0]);
        for (int k = 0; k < N; k++)
            sum = sum + ((BW'(d[W+5*k +: 5]) << (W + 5*k)) % m);
`endif
        return sum[AW-1:0];
    endfunction

    function automatic logic [TOT-1:0] rand_op();
        logic [TOT-1:0] d;
        d = '0;
        for (int i = 0; i < (TOT + 31) / 32; i++)
            d = (d << 32) | TOT'($urandom());
        return d;
    endfunction

    // Monitor: a handshake completes on the posedge after this negedge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got low64=%h with empty scoreboard", bus.out_data[63:0]);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand)
                bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [TOT-1:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        exp_q.push_back(model(d));
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        logic [TOT-1:0] d;
        logic [AW-1:0]  e;
        int lat;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", AW'(bus.in_ready), AW'(1));
        check("rst_out_valid", AW'(bus.out_valid), AW'(0));
        check("rst_busy", AW'(bus.busy), AW'(0));
        check("rst_out_data", bus.out_data, '0);

        // Zero operand and output latency from the accept edge.
        send('0);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef MODQ_FINAL_SUB_EN
        check("latency_zero", AW'(lat), AW'(N + 1));
`else
        check("latency_zero", AW'(lat), AW'(N));
`endif
        drain();

        send(TOT'(5));
        drain();

        d = '0;
        d[W + 15] = 1'b1;
        send(d);
        drain();

        send('1);
        drain();

        // Output back-pressure: result must hold, no new operand accepted.
        d = rand_op();
        e = model(d);
        bus.out_ready = 1'b0;
        send(d);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("stall_valid", AW'(bus.out_valid), AW'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_data", bus.out_data, e);
            check("stall_in_ready", AW'(bus.in_ready), AW'(0));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_ack_in_ready", AW'(bus.in_ready), AW'(1));
        check("post_ack_out_valid", AW'(bus.out_valid), AW'(0));
        drain();

        // Reset while accumulating at cnt=3 drops the partial result.
        send(rand_op());
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_out_valid", AW'(bus.out_valid), AW'(0));
        check("midrst_in_ready", AW'(bus.in_ready), AW'(1));
        check("midrst_out_data", bus.out_data, '0);
        check("midrst_busy", AW'(bus.busy), AW'(0));
        reset = 1'b0;
        send(rand_op());
        drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = rand_op();
            if (i % 5 == 0)
                d[W-1:0] = '0;
            send(d);
        end
        drain();
        rdy_rand = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
